bin2bcd_dspl_fmt: RTL and testbench

//  Sequential binary-to-BCD formatter feeding the 8-digit Nexys A7 display driver.

---
 rtl/bin2bcd_dspl_fmt_pkg.sv | 35 +++
 rtl/bin2bcd_dspl_fmt_add3.sv | 14 +
 rtl/bin2bcd_dspl_fmt.sv | 154 +++++++++++++++
 tb/tb_bin2bcd_dspl_fmt.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_dspl_fmt_pkg.sv
// Shared definitions for the binary-to-BCD display formatter:
// digit-word field positions, blank/overflow constants, FSM encoding
// and a helper that packs one display digit word.
package bin2bcd_dspl_fmt_pkg;

  // Digit word layout {en, hex[3:0], dp_n}
  localparam int W_EN     = 5;
  localparam int W_HEX_LO = 1;
  localparam int W_DP     = 0;

  // Blank words: d1..d7 blank with en=1, d8 blank with en=0
  localparam logic [5:0] BLANK_LO = 6'b100001;
  localparam logic [5:0] BLANK_HI = 6'b000001;
  localparam logic [3:0] HEX_U    = 4'hF;

  localparam int unsigned MAX_DISP = 32'd99_999_999;
  localparam int          N_DIG    = 8;
  localparam int          N_BCD    = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FMT   = 2'd2
  } state_e;

  function automatic logic [5:0] dig_word(input logic en, input logic [3:0] hex, input logic dp_n);
    logic [5:0] w;
    w               = '0;
    w[W_EN]         = en;
    w[W_HEX_LO +: 4] = hex;
    w[W_DP]         = dp_n;
    return w;
  endfunction

endpackage

// File: rtl/bin2bcd_dspl_fmt_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or
// more so that the following left shift carries correctly into the next digit.
//  nib_i  in  4  BCD nibble before correction
//  nib_o  out 4  corrected nibble (max 12, never wraps)
module bcd_add3
  import bin2bcd_dspl_fmt_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin2bcd_dspl_fmt.sv
// Sequential binary-to-BCD formatter for the 8-digit display driver.
// Converts one bit per clock with double-dabble, then formats eight digit
// words with optional leading-zero blanking and overflow indication.
//  clock   in   1      system clock
//  reset   in   1      asynchronous, active-low reset
//  start   in   1      conversion request, sampled only when idle
//  bin_in  in   BIN_W  unsigned value, captured on acceptance
//  dp_sel  in   8      decimal point per digit (bit i -> d(i+1)), captured with bin_in
//  busy    out  1      conversion in progress
//  done    out  1      one-cycle pulse, digit words updated on the same edge
//  ovf     out  1      last value exceeded 99_999_999, held until next done
//  d1..d8  out  6      digit words {en, hex, dp_n}, d1 rightmost
module bin2bcd_dspl_fmt
  import bin2bcd_dspl_fmt_pkg::*;
#(
  parameter int BIN_W = 27,
  parameter bit LZB   = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  input  logic [7:0]       dp_sel,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [5:0]       d1,
  output logic [5:0]       d2,
  output logic [5:0]       d3,
  output logic [5:0]       d4,
  output logic [5:0]       d5,
  output logic [5:0]       d6,
  output logic [5:0]       d7,
  output logic [5:0]       d8
);

  localparam int SR_W  = 4 * N_BCD + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  state_e                     state_q, state_d;
  logic [SR_W-1:0]            sr_q, sr_d;
  logic [SR_W-1:0]            sr_adj;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [7:0]                 dp_q, dp_d;
  logic                       ovf_pend_q, ovf_pend_d;
  logic                       done_q, done_d;
  logic                       ovf_q, ovf_d;
  logic [N_DIG-1:0][5:0]      dw_q, dw_d;
  logic [N_DIG-1:0][5:0]      fmt_w;
  logic [4*N_BCD-1:0]         bcd_adj;
  logic [3:0]                 dig_c;
  logic                       seen_c;
  logic                       lit_c;

  // Corrected BCD field of the shift register, one nibble per instance
  for (genvar g = 0; g < N_BCD; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (sr_q[BIN_W + 4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  assign sr_adj = {bcd_adj, sr_q[BIN_W-1:0]};

  // Digit words from the finished conversion. Walking from d8 down, a digit
  // stays lit once any non-zero digit at or above it has been seen; d1 is
  // always lit so a zero value still shows "0".
  always_comb begin
    fmt_w  = '0;
    seen_c = 1'b0;
    dig_c  = 4'd0;
    lit_c  = 1'b0;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      dig_c    = sr_q[BIN_W + 4*k +: 4];
      seen_c   = seen_c | (dig_c != 4'd0);
      lit_c    = ovf_pend_q | ~LZB | seen_c | (k == 0);
      fmt_w[k] = dig_word((k == N_DIG - 1) ? lit_c : ~lit_c,
                          ovf_pend_q ? HEX_U : dig_c,
                          ~dp_q[k]);
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    dp_d       = dp_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    dw_d       = dw_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d       = {{(4*N_BCD){1'b0}}, bin_in};
          dp_d       = dp_sel;
          cnt_d      = CNT_W'(BIN_W - 1);
          ovf_pend_d = (32'(bin_in) > MAX_DISP);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = sr_adj << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_FMT;
        end
      end
      ST_FMT: begin
        dw_d    = fmt_w;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and display outputs: cleared to the all-blank pattern by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dw_q    <= {BLANK_HI, {(N_DIG-1){BLANK_LO}}};
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dw_q    <= dw_d;
    end
  end

  // Conversion datapath: always loaded before use, needs no reset
  always_ff @(posedge clock) begin
    sr_q       <= sr_d;
    cnt_q      <= cnt_d;
    dp_q       <= dp_d;
    ovf_pend_q <= ovf_pend_d;
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign d1   = dw_q[0];
  assign d2   = dw_q[1];
  assign d3   = dw_q[2];
  assign d4   = dw_q[3];
  assign d5   = dw_q[4];
  assign d6   = dw_q[5];
  assign d7   = dw_q[6];
  assign d8   = dw_q[7];

endmodule

// File: tb/tb_bin2bcd_dspl_fmt.sv
// Bench for bin2bcd_dspl_fmt: two instances (leading-zero blanking on/off)
// share stimulus; expected digit words and completion cycles are queued
// when a conversion is issued and checked whenever done is seen.
module tb_bin2bcd_dspl_fmt;

  localparam int BIN_W = 27;
  localparam int LAT   = BIN_W + 1;

  typedef struct packed {
    logic [31:0] dig;
    logic [7:0]  bm;
    logic [7:0]  dp;
    logic        ov;
    logic [31:0] ecyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic [7:0]       dp;

  logic       busy1, done1, ovf1, busy0, done0, ovf0;
  logic [5:0] a1, a2, a3, a4, a5, a6, a7, a8;
  logic [5:0] b1, b2, b3, b4, b5, b6, b7, b8;
  logic [7:0][5:0] w1, w0;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q1[$];
  exp_t q0[$];

  localparam logic [47:0] ALL_BLANK = {6'h01, {7{6'h21}}};

  bin2bcd_dspl_fmt #(.BIN_W(BIN_W), .LZB(1'b1)) u_dut (
    .clock(clk), .reset(rst_n), .start(start), .bin_in(bin), .dp_sel(dp),
    .busy(busy1), .done(done1), .ovf(ovf1),
    .d1(a1), .d2(a2), .d3(a3), .d4(a4), .d5(a5), .d6(a6), .d7(a7), .d8(a8)
  );

  bin2bcd_dspl_fmt #(.BIN_W(BIN_W), .LZB(1'b0)) u_dut_nz (
    .clock(clk), .reset(rst_n), .start(start), .bin_in(bin), .dp_sel(dp),
    .busy(busy0), .done(done0), .ovf(ovf0),
    .d1(b1), .d2(b2), .d3(b3), .d4(b4), .d5(b5), .d6(b6), .d7(b7), .d8(b8)
  );

  assign w1 = {a8, a7, a6, a5, a4, a3, a2, a1};
  assign w0 = {b8, b7, b6, b5, b4, b3, b2, b1};

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Digit word as the display driver expects it: d8 lights with en=1,
  // d1..d7 light with en=0; overflow lights everything as "U".
  function automatic logic [5:0] exp_word(input exp_t e, input int k);
    logic       lit;
    logic [3:0] hex;
    lit = e.ov | ~e.bm[k];
    hex = e.ov ? 4'hF : e.dig[4*k +: 4];
    return {(k == 7) ? lit : ~lit, hex, ~e.dp[k]};
  endfunction

  task automatic check_done(input string tag, input exp_t e, input logic [7:0][5:0] w, input logic o);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_d%0d", tag, k + 1), 64'(w[k]), 64'(exp_word(e, k)));
    chk({tag, "_ovf"}, 64'(o), 64'(e.ov));
    chk({tag, "_latency"}, 64'(cyc), 64'(e.ecyc));
  endtask

  task automatic push(input logic [31:0] dig, input logic [7:0] bm, input logic [7:0] d,
                      input logic ov, input int acc);
    exp_t e;
    e.dig  = dig;
    e.bm   = bm;
    e.dp   = d;
    e.ov   = ov;
    e.ecyc = 32'(acc + LAT);
    q1.push_back(e);
    e.bm   = 8'h00;
    q0.push_back(e);
  endtask

  task automatic issue(input logic [BIN_W-1:0] b, input logic [7:0] d, input logic [31:0] dig,
                       input logic [7:0] bm, input logic ov, input bit hold);
    @(negedge clk);
    bin   = b;
    dp    = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    push(dig, bm, d, ov, cyc);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 80; i++) begin
      if (q1.size() == 0 && q0.size() == 0) break;
      @(negedge clk);
    end
    chk({nm, "_pending"}, 64'(q1.size() + q0.size()), 64'd0);
  endtask

  task automatic convert(input logic [BIN_W-1:0] b, input logic [7:0] d, input logic [31:0] dig,
                         input logic [7:0] bm, input logic ov, input string nm);
    issue(b, d, dig, bm, ov, 1'b0);
    wait_idle(nm);
  endtask

  initial begin
    int acc;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    dp    = 8'h00;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (done1) begin
          if (q1.size() == 0) chk("unexpected_done_lzb1", 64'd1, 64'd0);
          else begin
            e = q1.pop_front();
            check_done("lzb1", e, w1, ovf1);
          end
        end
        if (done0) begin
          if (q0.size() == 0) chk("unexpected_done_lzb0", 64'd1, 64'd0);
          else begin
            e = q0.pop_front();
            check_done("lzb0", e, w0, ovf0);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_ovf", 64'(ovf1), 64'd0);
    chk("rst_words_lzb1", 64'(w1), 64'(ALL_BLANK));
    chk("rst_words_lzb0", 64'(w0), 64'(ALL_BLANK));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-conversion aborts without done
    @(negedge clk);
    bin   = 27'd12_345_678;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    chk("abort_busy_before", 64'(busy1), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_done", 64'(done1), 64'd0);
    chk("abort_words", 64'(w1), 64'(ALL_BLANK));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    chk("abort_words_after", 64'(w1), 64'(ALL_BLANK));

    convert(27'd12_345_678, 8'h00, 32'h1234_5678, 8'h00, 1'b0, "v12345678");
    repeat (5) @(negedge clk);
    chk("hold_d8", 64'(a8), 64'(6'b1_0001_1));
    chk("hold_busy", 64'(busy1), 64'd0);

    convert(27'd0, 8'h00, 32'h0000_0000, 8'hFE, 1'b0, "vzero");
    convert(27'd1_000_305, 8'h04, 32'h0100_0305, 8'h80, 1'b0, "v1000305");

    convert(27'd100_000_000, 8'h00, 32'h0000_0000, 8'h00, 1'b1, "vovf");
    repeat (3) @(negedge clk);
    chk("ovf_held", 64'(ovf1), 64'd1);
    convert(27'd42, 8'h00, 32'h0000_0042, 8'hFC, 1'b0, "v42");
    convert(27'd99_999_999, 8'h81, 32'h9999_9999, 8'h00, 1'b0, "vmaxdisp");
    convert(27'h7FF_FFFF, 8'h00, 32'h0000_0000, 8'h00, 1'b1, "vmaxbin");

    // start pulse while busy is ignored
    issue(27'd555, 8'h00, 32'h0000_0555, 8'hF8, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("ignore_busy", 64'(busy1), 64'd1);
    bin   = 27'd999;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("v555");
    repeat (40) @(negedge clk);

    // start held high: next value accepted on the edge ending the done cycle
    issue(27'd7, 8'h01, 32'h0000_0007, 8'hFE, 1'b0, 1'b1);
    n = 0;
    while (!done1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("held_first_done", 64'(done1), 64'd1);
    bin = 27'd4321;
    dp  = 8'h00;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    push(32'h0000_4321, 8'hF0, 8'h00, 1'b0, acc);
    wait_idle("vheld");
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
